// File: rtl/csr_file_pkg.sv
// csr_file_pkg: CSR addresses, field bit positions and packing helpers for csr_file.
package csr_file_pkg;
   typedef logic [11:0] csr_addr_t;
   localparam csr_addr_t CSR_MSTATUS   = 12'h300;
   localparam csr_addr_t CSR_MISA      = 12'h301;
   localparam csr_addr_t CSR_MIE       = 12'h304;
   localparam csr_addr_t CSR_MTVEC     = 12'h305;
   localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
   localparam csr_addr_t CSR_MEPC      = 12'h341;
   localparam csr_addr_t CSR_MCAUSE    = 12'h342;
   localparam csr_addr_t CSR_MTVAL     = 12'h343;
   localparam csr_addr_t CSR_MIP       = 12'h344;
   localparam csr_addr_t CSR_MHARTID   = 12'hF14;
   localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
   localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
   localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
   localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
   localparam csr_addr_t CSR_CYCLE     = 12'hC00;
   localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
   localparam csr_addr_t CSR_INSTRET   = 12'hC02;
   localparam csr_addr_t CSR_INSTRETH  = 12'hC82;
   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MIX_EXT_BIT      = 11;
   localparam int MIX_TMR_BIT      = 7;
   localparam int MIX_SW_BIT       = 3;
   localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
   localparam logic [31:0] MIX_MASK     = 32'h0000_0888;
   // b = {external, timer, software}
   function automatic logic [31:0] pack_mix(input logic [2:0] b);
      logic [31:0] v;
      v = '0;
      v[MIX_EXT_BIT] = b[2];
      v[MIX_TMR_BIT] = b[1];
      v[MIX_SW_BIT]  = b[0];
      return v;
   endfunction
endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: CSR access and trap-update bus between the control/execute side and csr_file.
interface csr_file_if;
   logic [11:0] raddr;
   logic [31:0] rdata;
   logic        we;
   logic [11:0] waddr;
   logic [31:0] wdata;
   logic        instret;
   logic        irq_external;
   logic        irq_timer;
   logic        irq_software;
   logic        ie_type;
   logic        set_cause;
   logic [3:0]  trap_cause;
   logic        set_epc;
   logic [31:0] trap_epc;
   logic        set_mtval;
   logic [31:0] trap_mtval;
   logic        mstatus_ie_clear;
   logic        mstatus_ie_set;
   logic        mstatus_ie;
   logic        mie_external;
   logic        mie_timer;
   logic        mie_sw;
   logic        mip_external;
   logic        mip_timer;
   logic        mip_sw;
   logic [31:0] mtvec;
   logic [31:0] epc;
   modport master (
      output raddr, we, waddr, wdata, instret, irq_external, irq_timer, irq_software,
             ie_type, set_cause, trap_cause, set_epc, trap_epc, set_mtval, trap_mtval,
             mstatus_ie_clear, mstatus_ie_set,
      input  rdata, mstatus_ie, mie_external, mie_timer, mie_sw,
             mip_external, mip_timer, mip_sw, mtvec, epc
   );
   modport slave (
      input  raddr, we, waddr, wdata, instret, irq_external, irq_timer, irq_software,
             ie_type, set_cause, trap_cause, set_epc, trap_epc, set_mtval, trap_mtval,
             mstatus_ie_clear, mstatus_ie_set,
      output rdata, mstatus_ie, mie_external, mie_timer, mie_sw,
             mip_external, mip_timer, mip_sw, mtvec, epc
   );
endinterface

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit wrapping counter; a write to either half replaces it and skips that cycle's increment.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) value <= '0;
      else value <= (we_lo || we_hi) ? {we_hi ? wdata : value[63:32], we_lo ? wdata : value[31:0]}
                                     : value + 64'(inc);
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file serving CSR instructions and trap updates from the control unit.
// Define CSR_COUNTER_EN to add 64-bit mcycle/minstret with read-only cycle/instret shadows.
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
   parameter logic [31:0] HART_ID     = 32'd0
) (
   input logic       clk,
   input logic       rst_n,
   csr_file_if.slave bus
);
   logic        mie_b, mpie, mc_int, sw_ok, fwd;
   logic [3:0]  mc_code;
   logic [2:0]  mie_r, mip_r;
   logic [31:0] mepc, mtval, mscratch, mtvec, rd_cur, sw_val;
`ifdef CSR_COUNTER_EN
   logic [63:0] mcycle, minstret;
   csr_counter64 u_mcycle (
      .clk(clk), .rst_n(rst_n), .inc(1'b1),
      .we_lo(bus.we && bus.waddr == CSR_MCYCLE), .we_hi(bus.we && bus.waddr == CSR_MCYCLEH),
      .wdata(bus.wdata), .value(mcycle)
   );
   csr_counter64 u_minstret (
      .clk(clk), .rst_n(rst_n), .inc(bus.instret),
      .we_lo(bus.we && bus.waddr == CSR_MINSTRET), .we_hi(bus.we && bus.waddr == CSR_MINSTRETH),
      .wdata(bus.wdata), .value(minstret)
   );
`endif
   always_comb begin
      rd_cur = '0;
      case (bus.raddr)
         CSR_MSTATUS:  rd_cur = {24'b0, mpie, 3'b0, mie_b, 3'b0};
         CSR_MISA:     rd_cur = MISA_VALUE;
         CSR_MHARTID:  rd_cur = HART_ID;
         CSR_MIE:      rd_cur = pack_mix(mie_r);
         CSR_MTVEC:    rd_cur = mtvec;
         CSR_MSCRATCH: rd_cur = mscratch;
         CSR_MEPC:     rd_cur = mepc;
         CSR_MCAUSE:   rd_cur = {mc_int, 27'b0, mc_code};
         CSR_MTVAL:    rd_cur = mtval;
         CSR_MIP:      rd_cur = pack_mix(mip_r);
`ifdef CSR_COUNTER_EN
         CSR_MCYCLE, CSR_CYCLE:       rd_cur = mcycle[31:0];
         CSR_MCYCLEH, CSR_CYCLEH:     rd_cur = mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:   rd_cur = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: rd_cur = minstret[63:32];
`endif
         default:      rd_cur = '0;
      endcase
   end
   // Masked software write value, also used to forward a same-address write to the read port.
   always_comb begin
      sw_ok  = 1'b1;
      sw_val = bus.wdata;
      case (bus.waddr)
         CSR_MSTATUS:            sw_val = bus.wdata & MSTATUS_MASK;
         CSR_MIE:                sw_val = bus.wdata & MIX_MASK;
         CSR_MTVEC:              sw_val = bus.wdata & ~32'h2;
         CSR_MEPC:               sw_val = bus.wdata & ~32'h3;
         CSR_MCAUSE:             sw_val = {bus.wdata[31], 27'b0, bus.wdata[3:0]};
         CSR_MSCRATCH, CSR_MTVAL: sw_val = bus.wdata;
`ifdef CSR_COUNTER_EN
         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: sw_val = bus.wdata;
`endif
         default:                sw_ok = 1'b0;
      endcase
   end
   assign fwd       = bus.we && sw_ok && bus.waddr == bus.raddr;
   assign bus.rdata = fwd ? sw_val : rd_cur;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mie_b    <= 1'b0;
         mpie     <= 1'b0;
         mie_r    <= '0;
         mip_r    <= '0;
         mepc     <= '0;
         mc_int   <= 1'b0;
         mc_code  <= '0;
         mtval    <= '0;
         mscratch <= '0;
         mtvec    <= MTVEC_RESET;
      end else begin
         mip_r <= {bus.irq_external, bus.irq_timer, bus.irq_software};
         if (bus.mstatus_ie_clear) begin
            mpie  <= mie_b;
            mie_b <= 1'b0;
         end else if (bus.mstatus_ie_set) begin
            mie_b <= mpie;
            mpie  <= 1'b1;
         end else if (bus.we && bus.waddr == CSR_MSTATUS) begin
            mie_b <= sw_val[MSTATUS_MIE_BIT];
            mpie  <= sw_val[MSTATUS_MPIE_BIT];
         end
         if (bus.we && bus.waddr == CSR_MIE)
            mie_r <= {sw_val[MIX_EXT_BIT], sw_val[MIX_TMR_BIT], sw_val[MIX_SW_BIT]};
         if (bus.we && bus.waddr == CSR_MTVEC) mtvec <= sw_val;
         if (bus.we && bus.waddr == CSR_MSCRATCH) mscratch <= sw_val;
         if (bus.set_epc) mepc <= {bus.trap_epc[31:2], 2'b00};
         else if (bus.we && bus.waddr == CSR_MEPC) mepc <= sw_val;
         if (bus.set_cause) {mc_int, mc_code} <= {bus.ie_type, bus.trap_cause};
         else if (bus.we && bus.waddr == CSR_MCAUSE) {mc_int, mc_code} <= {sw_val[31], sw_val[3:0]};
         if (bus.set_mtval) mtval <= bus.trap_mtval;
         else if (bus.we && bus.waddr == CSR_MTVAL) mtval <= sw_val;
      end
   assign bus.mstatus_ie   = mie_b;
   assign bus.mie_external = mie_r[2];
   assign bus.mie_timer    = mie_r[1];
   assign bus.mie_sw       = mie_r[0];
   assign bus.mip_external = mip_r[2];
   assign bus.mip_timer    = mip_r[1];
   assign bus.mip_sw       = mip_r[0];
   assign bus.mtvec        = mtvec;
   assign bus.epc          = mepc;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed self-checking bench for csr_file (counter checks follow CSR_COUNTER_EN).
module tb_csr_file;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   csr_file_if bus();
   csr_file #(.MTVEC_RESET(32'h0000_0100), .MISA_VALUE(32'h4000_0100), .HART_ID(32'd0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input logic [11:0] a);
      bus.raddr = a;
      #1;
   endtask
   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.we = 1'b1;
      bus.waddr = a;
      bus.wdata = d;
      tick();
      bus.we = 1'b0;
   endtask
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask
   task automatic test_reset();
      chk("rst_mtvec_o", bus.mtvec, 32'h100);
      chk("rst_mie_o", 32'(bus.mstatus_ie), 32'h0);
      chk("rst_epc_o", bus.epc, 32'h0);
      rd(12'h342); chk("rst_mcause", bus.rdata, 32'h0);
      rd(12'h305); chk("rst_mtvec_rd", bus.rdata, 32'h100);
      rd(12'h301); chk("misa", bus.rdata, 32'h4000_0100);
      rd(12'hF14); chk("mhartid", bus.rdata, 32'h0);
      rd(12'h344); chk("rst_mip", bus.rdata, 32'h0);
   endtask
   task automatic test_mstatus();
      bus.raddr = 12'h300;
      bus.we = 1'b1; bus.waddr = 12'h300; bus.wdata = 32'h8;
      #1; chk("mstatus_fwd", bus.rdata, 32'h8);
      tick(); bus.we = 1'b0;
      rd(12'h300); chk("mstatus_wr", bus.rdata, 32'h8);
      chk("mstatus_ie_o", 32'(bus.mstatus_ie), 32'h1);
      bus.mstatus_ie_clear = 1'b1; tick(); bus.mstatus_ie_clear = 1'b0;
      rd(12'h300); chk("ie_clear", bus.rdata, 32'h80);
      chk("ie_clear_o", 32'(bus.mstatus_ie), 32'h0);
      bus.mstatus_ie_set = 1'b1; tick(); bus.mstatus_ie_set = 1'b0;
      rd(12'h300); chk("ie_set", bus.rdata, 32'h88);
      bus.mstatus_ie_set = 1'b1; bus.mstatus_ie_clear = 1'b1; tick();
      bus.mstatus_ie_set = 1'b0; bus.mstatus_ie_clear = 1'b0;
      rd(12'h300); chk("clear_wins", bus.rdata, 32'h80);
      wr(12'h300, 32'hFFFF_FFFF);
      rd(12'h300); chk("mstatus_mask", bus.rdata, 32'h88);
   endtask
   task automatic test_trap();
      bus.set_cause = 1'b1; bus.ie_type = 1'b1; bus.trap_cause = 4'hB;
      bus.set_epc = 1'b1; bus.trap_epc = 32'h103;
      bus.set_mtval = 1'b1; bus.trap_mtval = 32'hDEAD_BEEF;
      tick();
      bus.set_cause = 1'b0; bus.ie_type = 1'b0; bus.set_epc = 1'b0; bus.set_mtval = 1'b0;
      rd(12'h342); chk("trap_mcause", bus.rdata, 32'h8000_000B);
      chk("trap_epc_o", bus.epc, 32'h100);
      rd(12'h341); chk("trap_mepc_rd", bus.rdata, 32'h100);
      rd(12'h343); chk("trap_mtval", bus.rdata, 32'hDEAD_BEEF);
      wr(12'h342, 32'hFFFF_FFFF);
      rd(12'h342); chk("mcause_sw", bus.rdata, 32'h8000_000F);
   endtask
   task automatic test_collision();
      bus.set_epc = 1'b1; bus.trap_epc = 32'h400;
      wr(12'h341, 32'h200);
      bus.set_epc = 1'b0;
      chk("coll_same_epc", bus.epc, 32'h400);
      bus.set_epc = 1'b1; bus.trap_epc = 32'h500;
      wr(12'h340, 32'h55);
      bus.set_epc = 1'b0;
      chk("coll_diff_epc", bus.epc, 32'h500);
      rd(12'h340); chk("coll_diff_mscratch", bus.rdata, 32'h55);
      wr(12'h341, 32'h0000_0207);
      chk("mepc_sw_mask", bus.epc, 32'h204);
   endtask
   task automatic test_irq();
      wr(12'h304, 32'hFFFF_FFFF);
      rd(12'h304); chk("mie_mask", bus.rdata, 32'h888);
      chk("mie_bits_o", {29'b0, bus.mie_external, bus.mie_timer, bus.mie_sw}, 32'h7);
      bus.irq_timer = 1'b1;
      #1; chk("mip_not_yet", 32'(bus.mip_timer), 32'h0);
      tick();
      chk("mip_timer_o", 32'(bus.mip_timer), 32'h1);
      rd(12'h344); chk("mip_rd", bus.rdata, 32'h80);
      bus.we = 1'b1; bus.waddr = 12'h344; bus.wdata = 32'h0;
      #1; chk("mip_no_fwd", bus.rdata, 32'h80);
      tick(); bus.we = 1'b0;
      rd(12'h344); chk("mip_ro", bus.rdata, 32'h80);
      bus.irq_timer = 1'b0; bus.irq_external = 1'b1;
      tick();
      rd(12'h344); chk("mip_level", bus.rdata, 32'h800);
      bus.irq_external = 1'b0;
      tick();
      chk("mip_ext_clr", 32'(bus.mip_external), 32'h0);
   endtask
   task automatic test_misc();
      wr(12'h305, 32'hFFFF_FFFF);
      chk("mtvec_mask", bus.mtvec, 32'hFFFF_FFFD);
      wr(12'h301, 32'h0);
      rd(12'h301); chk("misa_ro", bus.rdata, 32'h4000_0100);
      bus.raddr = 12'h7C0;
      bus.we = 1'b1; bus.waddr = 12'h7C0; bus.wdata = 32'h1234;
      #1; chk("unimpl_fwd", bus.rdata, 32'h0);
      tick(); bus.we = 1'b0;
      rd(12'h7C0); chk("unimpl_rd", bus.rdata, 32'h0);
   endtask
   task automatic test_counters();
`ifdef CSR_COUNTER_EN
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0);
      rd(12'hB00); chk("mcycle_lo_held", bus.rdata, 32'hFFFF_FFFF);
      rd(12'hB80); chk("mcycle_hi_held", bus.rdata, 32'h0);
      tick();
      rd(12'hB00); chk("mcycle_wrap_lo", bus.rdata, 32'h0);
      rd(12'hB80); chk("mcycle_carry_hi", bus.rdata, 32'h1);
      rd(12'hC80); chk("cycleh_shadow", bus.rdata, 32'h1);
      rd(12'hB02); chk("minstret_idle", bus.rdata, 32'h0);
      bus.instret = 1'b1;
      repeat (3) tick();
      bus.instret = 1'b0;
      tick();
      rd(12'hB02); chk("minstret_3", bus.rdata, 32'h3);
      rd(12'hC02); chk("instret_shadow", bus.rdata, 32'h3);
      bus.instret = 1'b1;
      wr(12'hB02, 32'hA);
      bus.instret = 1'b0;
      rd(12'hB02); chk("minstret_wr_suppress", bus.rdata, 32'hA);
`else
      wr(12'hB00, 32'h5);
      rd(12'hB00); chk("mcycle_absent", bus.rdata, 32'h0);
      rd(12'hC00); chk("cycle_absent", bus.rdata, 32'h0);
      rd(12'hB82); chk("minstreth_absent", bus.rdata, 32'h0);
`endif
   endtask
   task automatic test_reset_mid();
      bus.set_cause = 1'b1; bus.ie_type = 1'b1; bus.trap_cause = 4'h3;
      bus.mstatus_ie_set = 1'b1;
      tick();
      bus.set_cause = 1'b0; bus.ie_type = 1'b0; bus.mstatus_ie_set = 1'b0;
      bus.raddr = 12'h342;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_mtvec_o", bus.mtvec, 32'h100);
      chk("mid_ie_o", 32'(bus.mstatus_ie), 32'h0);
      chk("mid_epc_o", bus.epc, 32'h0);
      chk("mid_mcause", bus.rdata, 32'h0);
      rd(12'h304); chk("mid_mie", bus.rdata, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
   endtask
   initial begin
      bus.raddr = '0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.instret = 1'b0;
      bus.irq_external = 1'b0; bus.irq_timer = 1'b0; bus.irq_software = 1'b0;
      bus.ie_type = 1'b0; bus.set_cause = 1'b0; bus.trap_cause = '0;
      bus.set_epc = 1'b0; bus.trap_epc = '0; bus.set_mtval = 1'b0; bus.trap_mtval = '0;
      bus.mstatus_ie_clear = 1'b0; bus.mstatus_ie_set = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_mstatus();
      test_trap();
      test_collision();
      test_irq();
      test_misc();
      test_reset_mid();
      test_counters();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file, directly downstream of the pipeline control/trap unit.
- Consumes the control unit's trap-side update strobes (cause, epc, mtval, mstatus IE set/clear).
- Serves CSR instruction reads and writes from the execute/writeback path.
- Returns interrupt-enable, interrupt-pending, mtvec and mepc state to the control unit every cycle.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (BASE and MODE).
- MISA_VALUE, 32'h4000_0100, constant read value of misa (RV32I).
- HART_ID, 0, constant read value of mhartid.

Ports:
- clk_i  in  1  clock
- n_rst_i  in  1  asynchronous active-low reset
- raddr_i  in  12  CSR read address
- rdata_o  out  32  CSR read data, combinational
- we_i  in  1  software CSR write enable; final value already computed by exu
- waddr_i  in  12  CSR write address
- wdata_i  in  32  CSR write data
- instret_i  in  1  one instruction retired this cycle
- irq_external_i / irq_timer_i / irq_software_i  in  1 each  raw interrupt lines
- ie_type_i  in  1  1 = interrupt, 0 = exception
- set_cause_i  in  1  load mcause
- trap_cause_i  in  4  cause code
- set_epc_i  in  1  load mepc
- epc_i  in  32  trapping pc
- set_mtval_i  in  1  load mtval
- mtval_i  in  32  trap value
- mstatus_ie_clear_i  in  1  trap entry
- mstatus_ie_set_i  in  1  mret
- mstatus_ie_o  out  1  mstatus.MIE
- mie_external_o / mie_timer_o / mie_sw_o  out  1 each  mie bits 11 / 7 / 3
- mip_external_o / mip_timer_o / mip_sw_o  out  1 each  mip bits 11 / 7 / 3
- mtvec_o  out  32  mtvec
- epc_o  out  32  mepc

Behaviour:
- Reset (async, n_rst_i=0):
  - mstatus.MIE=0, mstatus.MPIE=0, mie=0, mip=0.
  - mepc=0, mcause=0, mtval=0, mscratch=0.
  - mtvec=MTVEC_RESET; counters=0.
  - Outputs follow these registers.
- Implemented CSRs:
  - mstatus 0x300: only MIE bit3 and MPIE bit7 are stored; other bits read 0.
  - misa 0x301, mhartid 0xF14: read-only constants.
  - mie 0x304: bits 11/7/3 writable; other bits read 0.
  - mtvec 0x305: fully writable; bit1 forced to 0.
  - mscratch 0x340: fully writable.
  - mepc 0x341: bits[1:0] forced to 0 on every write path.
  - mcause 0x342: reads {ie_type,27'b0,cause[3:0]}; software write stores wdata[31] and wdata[3:0].
  - mtval 0x343: fully writable.
  - mip 0x344: read-only to software; writes ignored.
  - Any other address reads 0; writes to it are ignored.
- mip: each bit is irq_*_i registered through one flop. A pending bit is visible one cycle after the line rises and clears one cycle after it falls (level-sensitive, no latching).
- Read path:
  - rdata_o is combinational from raddr_i.
  - When we_i=1 and waddr_i==raddr_i, rdata_o returns the post-write masked value (forwarding). Zero-cycle visibility.
- Trap updates (take effect at the clock edge):
  - mstatus_ie_clear_i: MPIE<=MIE, MIE<=0.
  - mstatus_ie_set_i: MIE<=MPIE, MPIE<=1.
  - Both clear and set in the same cycle: clear wins.
  - set_cause_i loads mcause={ie_type_i,cause}. set_epc_i loads epc_i. set_mtval_i loads mtval_i.
- Collision rule: a trap strobe and a software write to the same CSR in the same cycle resolve to the trap value. A software write to a different CSR proceeds normally.

Optional Feature:
- CSR_COUNTER_EN: adds 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), with read-only shadows cycle/instret (0xC00/0xC80/0xC02/0xC82).
- mcycle increments every cycle. minstret increments when instret_i=1.
- Both wrap from 2^64-1 to 0.
- A software write to either half replaces that half, and suppresses that counter's increment in that cycle.
- Low-half carry into the high half is computed in the same cycle.
- Without the macro, all these addresses read 0 and writes to them are ignored.

Decomposition:
- defines.v holds:
  - CSR address constants (CSR_MSTATUS … CSR_MINSTRETH).
  - Bit positions MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7, MIX_EXT_BIT=11, MIX_TMR_BIT=7, MIX_SW_BIT=3.
- One sub-module csr_counter64: 64-bit counter with inc_i, write-low/write-high ports and wrap. Instantiated twice, only under CSR_COUNTER_EN.

Test Plan:
- Reset mid-run → mtvec_o=MTVEC_RESET, mstatus_ie_o=0, epc_o=0, rdata_o(0x342)=0 with no clock edge required.
- Write mstatus=0x8 then pulse mstatus_ie_clear_i → MIE=0, MPIE=1. Then pulse mstatus_ie_set_i → MIE=1, MPIE=1.
- set_cause_i=1, ie_type_i=1, trap_cause_i=4'hB, set_epc_i=1, epc_i=0x103 → mcause reads 0x8000000B, epc_o=0x100.
- Same cycle: we_i to 0x341 with 0x200, plus set_epc_i with epc_i=0x400 → epc_o=0x400.
- Raise irq_timer_i with mie timer bit set → mip_timer_o=1 after 1 cycle, read 0x344=0x80. Write 0x344=0 → unchanged.
- CSR_COUNTER_EN: write mcycle low=0xFFFFFFFF, high=0 → next cycle mcycleh=1, mcycle=0. With instret_i held 3 cycles, minstret advances by 3.
